// File: rtl/mem_dump_reader.sv
// Walks an inclusive address range of a synchronous-read memory and streams {addr, data} over valid/ready.
// Optional DUMP_SKIP_ZERO_EN: zero-valued words are read but not presented and not counted.
module mem_dump_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count
);

  // state   | meaning
  // IDLE    | waiting for start
  // ISSUE   | read strobe for word at cur
  // CAPTURE | read data returns, latched into out_data/out_addr
  // SEND    | word presented until accepted
  // FINISH  | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, FINISH} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur, cur_nxt, lim;
  logic                  last_word;
  logic                  accept_start;
  logic                  handshake;
  logic                  skip_word;

  assign last_word    = (cur == lim);
  assign accept_start = (state == IDLE) && start;
  assign handshake    = (state == SEND) && out_ready;

`ifdef DUMP_SKIP_ZERO_EN
  assign skip_word = (mem_rd_data == '0);
`else
  assign skip_word = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // cur is compared against lim before incrementing, so lim at the top of the space never wraps
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    case (state)
      IDLE: begin
        if (start) begin
          cur_nxt   = first_addr;
          state_nxt = (first_addr > last_addr) ? FINISH : ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: begin
        if (!skip_word) begin
          state_nxt = SEND;
        end else if (last_word) begin
          state_nxt = FINISH;
        end else begin
          cur_nxt   = cur + 1'b1;
          state_nxt = ISSUE;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_word) begin
            state_nxt = FINISH;
          end else begin
            cur_nxt   = cur + 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state == ISSUE);
    out_valid = (state == SEND);
    busy      = (state != IDLE);
    done      = (state == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= '0;
      lim        <= '0;
      mem_addr   <= '0;
      out_addr   <= '0;
      out_data   <= '0;
      word_count <= '0;
    end else begin
      cur <= cur_nxt;
      if (accept_start) lim <= last_addr;
      // mem_addr only moves when a read is about to be issued
      if (state_nxt == ISSUE) mem_addr <= cur_nxt;
      if (accept_start)    word_count <= '0;
      else if (handshake)  word_count <= word_count + 1'b1;
      if (state == CAPTURE && !skip_word) begin
        out_data <= mem_rd_data;
        out_addr <= cur;
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: expected word stream built from the memory contents and range.
// Honours DUMP_SKIP_ZERO_EN when the build defines it.
module tb_mem_dump_reader;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] first_addr, last_addr;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy, done;
  logic [AW:0]   word_count;

  mem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  typedef struct {int addr; logic [DW-1:0] data;} word_t;
  word_t exp_q[$];
  int    exp_count;
  int    checks = 0;
  int    errors = 0;
  int    done_count = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the words a dump of [f..l] must produce, in order
  task automatic start_dump(input int f, input int l);
    word_t w;
    exp_q.delete();
    exp_count = 0;
    for (int a = f; a <= l; a++) begin
`ifdef DUMP_SKIP_ZERO_EN
      if (mem[a] == 0) continue;
`endif
      w.addr = a;
      w.data = mem[a];
      exp_q.push_back(w);
      exp_count++;
    end
    first_addr = AW'(f);
    last_addr  = AW'(l);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c0 = done_count;
    int n  = 0;
    while (done_count == c0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done_seen"}, done_count - c0, 1);
  endtask

  task automatic wait_word_at(input int a, input string name);
    int n = 0;
    while (!(out_valid && out_addr == AW'(a)) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_reached_word"}, {out_valid, out_addr}, {1'b1, AW'(a)});
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rd_en"}, mem_rd_en, 0);
    check({name, "_mem_addr"}, mem_addr, 0);
    check({name, "_valid"}, out_valid, 0);
    check({name, "_out_addr"}, out_addr, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_count"}, word_count, 0);
  endtask

  // Compare process: every accepted word, held outputs while stalled, and dump completion
  always @(negedge clk) begin
    word_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        check("no_read_while_presenting", mem_rd_en, 0);
        check("busy_while_presenting", busy, 1);
        if (prev_stall) begin
          check("stall_addr_stable", out_addr, held_addr);
          check("stall_data_stable", out_data, held_data);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got addr %0d data %0h, expected none", out_addr, out_data);
          end else begin
            e = exp_q.pop_front();
            check("word_addr", out_addr, e.addr);
            check("word_data", out_data, e.data);
          end
        end
        prev_stall = !out_ready;
        held_addr  = out_addr;
        held_data  = out_data;
      end else begin
        prev_stall = 1'b0;
      end
      if (done) begin
        done_count++;
        check("done_all_words_sent", exp_q.size(), 0);
        check("done_word_count", word_count, exp_count);
      end
    end
  end

  initial begin
    int dc;
    for (int i = 0; i < (1 << AW); i++) mem[i] = i * 4 + 1;
    reset = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b1;
    exp_count = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic dump 0..3 with pinned pipeline timing
    start_dump(0, 3);
    check("t1_queue_size", exp_q.size(), 4);
    check("t1_issue_rd_en", mem_rd_en, 1);
    check("t1_issue_addr", mem_addr, 0);
    check("t1_issue_busy", busy, 1);
    @(posedge clk); #1;
    check("t1_capture_valid", out_valid, 0);
    @(posedge clk); #1;
    check("t1_first_valid", out_valid, 1);
    check("t1_first_addr", out_addr, 0);
    check("t1_first_data", out_data, 1);
    wait_done("t1");
    check("t1_done_low_after", done, 0);
    check("t1_idle_after", busy, 0);
    check("t1_count", word_count, 4);

    // Back-pressure on word 2
    start_dump(0, 3);
    wait_word_at(2, "t2");
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("t2_held_valid", out_valid, 1);
      check("t2_held_addr", out_addr, 2);
      check("t2_held_data", out_data, 9);
      check("t2_no_read", mem_rd_en, 0);
    end
    out_ready = 1'b1;
    wait_done("t2");
    check("t2_count", word_count, 4);

    // Top-of-space single word: no wrap
    start_dump(31, 31);
    check("t3_queue_size", exp_q.size(), 1);
    wait_done("t3");
    check("t3_count", word_count, 1);
    check("t3_last_addr", out_addr, 31);
    check("t3_last_data", out_data, 125);

    // Empty dump
    start_dump(5, 2);
    check("t4_done_next_cycle", done, 1);
    check("t4_no_valid", out_valid, 0);
    check("t4_count", word_count, 0);
    wait_done("t4");
    check("t4_done_low", done, 0);

    // Reset while presenting word 2
    start_dump(0, 3);
    wait_word_at(2, "t5");
    out_ready = 1'b0;
    dc = done_count;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_outputs("t5_after_reset");
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_no_done", done_count, dc);
    start_dump(0, 3);
    wait_done("t5_restart");
    check("t5_count", word_count, 4);

    // Start pulsed while busy is ignored
    start_dump(0, 3);
    repeat (3) @(posedge clk);
    #1;
    first_addr = 5'd10; last_addr = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6");
    check("t6_count", word_count, 4);
    check("t6_last_addr", out_addr, 3);

    // Zero words: skipped only when the option is built in
    mem[0] = 0; mem[1] = 7; mem[2] = 0; mem[3] = 9;
    start_dump(0, 3);
`ifdef DUMP_SKIP_ZERO_EN
    check("t7_queue_size", exp_q.size(), 2);
`else
    check("t7_queue_size", exp_q.size(), 4);
`endif
    wait_done("t7");
`ifdef DUMP_SKIP_ZERO_EN
    check("t7_count", word_count, 2);
`else
    check("t7_count", word_count, 4);
`endif
    check("t7_last_data", out_data, 9);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
